// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite SRAM responder.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 8;
   localparam int CNT_W     = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      R_WAIT = 3'd1,
      R_RESP = 3'd2,
      W_DATA = 3'd3,
      W_WAIT = 3'd4,
      B_RESP = 3'd5
   } state_e;

   typedef struct packed {
      logic [NUM_LANES-1:0][LANE_W-1:0] data;
      logic [1:0]                       resp;
   } rd_rsp_t;

endpackage

// File: rtl/sram_array.sv
// DEPTH x 32 word memory: one byte-lane instance per lane, synchronous
// byte-enabled write, asynchronous read, contents never reset.
module sram_array
   import axi_lite_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                             clock,
   input  logic                             we,
   input  logic [NUM_LANES-1:0]             be,
   input  logic [AW-1:0]                    addr,
   input  logic [NUM_LANES-1:0][LANE_W-1:0] wdata,
   output logic [NUM_LANES-1:0][LANE_W-1:0] rdata
);

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      sram_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
         .clock (clock),
         .we    (we && be[g]),
         .addr  (addr),
         .wdata (wdata[g]),
         .rdata (rdata[g])
      );
   end

endmodule

// Single byte lane of the word memory.
module sram_lane
   import axi_lite_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [LANE_W-1:0] wdata,
   output logic [LANE_W-1:0] rdata
);

   logic [LANE_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem_q[addr] <= wdata;
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/axi_lite_sram_responder.sv
// AXI4-Lite single-outstanding SRAM responder with programmable response latency.
// Define AXI_LITE_SRAM_RAND_DELAY_EN to add an LFSR-driven 0..7 cycle extra delay.
module axi_lite_sram_responder
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 4096,
   parameter int LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

   state_e                            state_q, state_d;
   logic [IDX_W-1:0]                  idx_q, idx_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   rd_rsp_t                           rsp_q, rsp_d;
   logic                              rvalid_q, rvalid_d;
   logic [1:0]                        bresp_q, bresp_d;
   logic                              bvalid_q, bvalid_d;

   logic                              in_range;
   logic                              mem_we;
   logic [NUM_LANES-1:0][LANE_W-1:0]  mem_rdata;
   logic [CNT_W-1:0]                  lat_load;

`ifdef AXI_LITE_SRAM_RAND_DELAY_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Fibonacci taps 8,6,5,4; free-running so each transaction sees a fresh delay
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) lfsr_q <= 8'hA5;
      else        lfsr_q <= lfsr_d;
   end

   assign lat_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[2:0]);
`else
   assign lat_load = CNT_W'(LATENCY - 1);
`endif

   assign in_range = (idx_q < DEPTH_IDX);
   assign mem_we   = (state_q == W_DATA) && wvalid && in_range;

   sram_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clock (clock),
      .we    (mem_we),
      .be    (wstrb),
      .addr  (idx_q[AW-1:0]),
      .wdata (wdata),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      rsp_d    = rsp_q;
      rvalid_d = rvalid_q;
      bresp_d  = bresp_q;
      bvalid_d = bvalid_q;
      case (state_q)
         IDLE: begin
            if (arvalid) begin
               idx_d   = araddr[ADDR_W-1:2];
               cnt_d   = lat_load;
               state_d = R_WAIT;
            end else if (awvalid) begin
               idx_d   = awaddr[ADDR_W-1:2];
               state_d = W_DATA;
            end
         end
         R_WAIT: begin
            if (cnt_q == '0) begin
               rsp_d.data = in_range ? mem_rdata : '0;
               rsp_d.resp = in_range ? RESP_OKAY : RESP_DECERR;
               rvalid_d   = 1'b1;
               state_d    = R_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         R_RESP: begin
            if (rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         W_DATA: begin
            // the array write itself happens on this edge via mem_we
            if (wvalid) begin
               bresp_d = in_range ? RESP_OKAY : RESP_DECERR;
               cnt_d   = lat_load;
               state_d = W_WAIT;
            end
         end
         W_WAIT: begin
            if (cnt_q == '0) begin
               bvalid_d = 1'b1;
               state_d  = B_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         B_RESP: begin
            if (bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         rsp_q    <= '0;
         rvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         bvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         rsp_q    <= rsp_d;
         rvalid_q <= rvalid_d;
         bresp_q  <= bresp_d;
         bvalid_q <= bvalid_d;
      end
   end

   // a read wins over a simultaneous write; the write waits for a later IDLE
   assign arready = (state_q == IDLE);
   assign awready = (state_q == IDLE) && !arvalid;
   assign wready  = (state_q == W_DATA);
   assign rdata   = rsp_q.data;
   assign rresp   = rsp_q.resp;
   assign rvalid  = rvalid_q;
   assign bresp   = bresp_q;
   assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_lite_sram_responder.sv
// Randomized self-checking bench for axi_lite_sram_responder against a word-array model.
module tb_axi_lite_sram_responder;

   localparam int ADDR_W  = 32;
   localparam int DEPTH   = 64;
   localparam int LATENCY = 3;
   localparam int TMO     = 40;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] araddr = '0;
   logic              arvalid = 1'b0;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready = 1'b1;
   logic [ADDR_W-1:0] awaddr = '0;
   logic              awvalid = 1'b0;
   logic              awready;
   logic [31:0]       wdata = '0;
   logic [3:0]        wstrb = '0;
   logic              wvalid = 1'b0;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [DEPTH];

   axi_lite_sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clock(clock), .reset(reset),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit in_rng(input logic [31:0] a);
      return (a >> 2) < DEPTH;
   endfunction

   function automatic bit lat_ok(input int lat);
`ifdef AXI_LITE_SRAM_RAND_DELAY_EN
      return lat >= LATENCY && lat <= LATENCY + 7;
`else
      return lat == LATENCY;
`endif
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      if (!in_rng(a)) return;
      w = model[a >> 2];
      for (int i = 0; i < 4; i++)
         if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model[a >> 2] = w;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [31:0] a);
      return in_rng(a) ? model[a >> 2] : 32'h0;
   endfunction

   function automatic logic [1:0] model_resp(input logic [31:0] a);
      return in_rng(a) ? 2'b00 : 2'b11;
   endfunction

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
      int t;
      @(negedge clock);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      t = 0;
      while (!arready && t < TMO) begin @(negedge clock); t++; end
      n_checks++;
      if (t >= TMO) begin n_fail++; $display("FAIL rd_ar_timeout: arready=%b required 1", arready); end
      @(posedge clock); #1 arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < TMO) begin @(posedge clock); #1; lat++; end
      d = rdata; r = rresp;
      @(posedge clock); #1;
      n_checks++;
      if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_drop: rvalid=%b required 0", rvalid); end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r, output int lat);
      int t;
      @(negedge clock);
      awaddr = a; awvalid = 1'b1; bready = 1'b1;
      t = 0;
      while (!awready && t < TMO) begin @(negedge clock); t++; end
      n_checks++;
      if (t >= TMO) begin n_fail++; $display("FAIL wr_aw_timeout: awready=%b required 1", awready); end
      @(posedge clock); #1 awvalid = 1'b0;
      wdata = d; wstrb = s; wvalid = 1'b1;
      n_checks++;
      if (wready !== 1'b1) begin n_fail++; $display("FAIL wr_wready: wready=%b required 1", wready); end
      @(posedge clock); #1 wvalid = 1'b0;
      lat = 0;
      while (!bvalid && lat < TMO) begin @(posedge clock); #1; lat++; end
      r = bresp;
      @(posedge clock); #1;
      n_checks++;
      if (bvalid !== 1'b0) begin n_fail++; $display("FAIL wr_bvalid_drop: bvalid=%b required 0", bvalid); end
   endtask

   task automatic test_reset;
      #3;
      n_checks++;
      if ({rvalid, bvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids: rvalid/bvalid=%b required 00", {rvalid, bvalid}); end
      n_checks++;
      if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
         n_fail++; $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b required 0", rdata, rresp, bresp);
      end
      n_checks++;
      if ({arready, awready, wready} !== 3'b110) begin n_fail++; $display("FAIL reset_ready: ar/aw/w=%b required 110", {arready, awready, wready}); end
      @(negedge clock); reset = 1'b1;
   endtask

   task automatic test_fill;
      logic [31:0] d; logic [1:0] r; int lat;
      for (int i = 0; i < DEPTH; i++) begin
         d = $urandom;
         do_write(i * 4, d, 4'hF, r, lat);
         model_write(i * 4, d, 4'hF);
         n_checks++;
         if (r !== 2'b00 || !lat_ok(lat)) begin n_fail++; $display("FAIL fill_bresp: bresp=%b lat=%0d required 00/%0d", r, lat, LATENCY); end
      end
   endtask

   task automatic test_basic;
      logic [31:0] d; logic [1:0] r; int lat;
      do_write(32'h10, 32'hDEADBEEF, 4'hF, r, lat);
      model_write(32'h10, 32'hDEADBEEF, 4'hF);
      n_checks++;
      if (r !== 2'b00) begin n_fail++; $display("FAIL basic_bresp: bresp=%b required 00", r); end
      n_checks++;
      if (!lat_ok(lat)) begin n_fail++; $display("FAIL basic_wlat: latency=%0d required %0d", lat, LATENCY); end
      do_read(32'h10, d, r, lat);
      n_checks++;
      if (d !== 32'hDEADBEEF || r !== 2'b00) begin n_fail++; $display("FAIL basic_read: rdata=%h rresp=%b required deadbeef/00", d, r); end
      n_checks++;
      if (!lat_ok(lat)) begin n_fail++; $display("FAIL basic_rlat: latency=%0d required %0d", lat, LATENCY); end
   endtask

   task automatic test_strobe;
      logic [31:0] d; logic [1:0] r; int lat;
      do_write(32'h20, 32'h11223344, 4'hF, r, lat);
      do_write(32'h20, 32'h000000AA, 4'b0001, r, lat);
      do_write(32'h22, 32'h0000BB00, 4'b0011, r, lat);
      do_write(32'h20, 32'hFFFFFFFF, 4'b0000, r, lat);
      n_checks++;
      if (r !== 2'b00) begin n_fail++; $display("FAIL strobe_zero_bresp: bresp=%b required 00", r); end
      model[8] = 32'h1122BB00;
      do_read(32'h23, d, r, lat);
      n_checks++;
      if (d !== 32'h1122BB00 || r !== 2'b00) begin n_fail++; $display("FAIL strobe_read: rdata=%h rresp=%b required 1122bb00/00", d, r); end
   endtask

   task automatic test_oor;
      logic [31:0] d; logic [1:0] r; int lat;
      do_read(4 * DEPTH, d, r, lat);
      n_checks++;
      if (r !== 2'b11 || d !== 32'h0) begin n_fail++; $display("FAIL oor_read: rdata=%h rresp=%b required 0/11", d, r); end
      do_write(4 * DEPTH, 32'hCAFEF00D, 4'hF, r, lat);
      n_checks++;
      if (r !== 2'b11) begin n_fail++; $display("FAIL oor_bresp: bresp=%b required 11", r); end
      do_read(0, d, r, lat);
      n_checks++;
      if (d !== model[0] || r !== 2'b00) begin n_fail++; $display("FAIL oor_word0: rdata=%h rresp=%b required %h/00", d, r, model[0]); end
   endtask

   task automatic test_random;
      logic [31:0] a, d, got; logic [3:0] s; logic [1:0] r; int lat;
      for (int i = 0; i < 80; i++) begin
         a = $urandom_range(0, 4 * DEPTH + 31);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            do_write(a, d, s, r, lat);
            model_write(a, d, s);
            n_checks++;
            if (r !== model_resp(a) || !lat_ok(lat)) begin
               n_fail++; $display("FAIL rand_write a=%h: bresp=%b lat=%0d required %b/%0d", a, r, lat, model_resp(a), LATENCY);
            end
         end else begin
            do_read(a, got, r, lat);
            n_checks++;
            if (got !== model_rdata(a) || r !== model_resp(a) || !lat_ok(lat)) begin
               n_fail++; $display("FAIL rand_read a=%h: rdata=%h rresp=%b lat=%0d required %h/%b/%0d",
                                  a, got, r, lat, model_rdata(a), model_resp(a), LATENCY);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp; int lat;
      exp = model[5];
      @(negedge clock);
      araddr = 32'h14; arvalid = 1'b1; rready = 1'b0;
      @(posedge clock); #1 arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < TMO) begin @(posedge clock); #1; lat++; end
      n_checks++;
      if (!lat_ok(lat)) begin n_fail++; $display("FAIL bp_latency: latency=%0d required %0d", lat, LATENCY); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         n_checks++;
         if (rvalid !== 1'b1 || rdata !== exp || rresp !== 2'b00 || arready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold%0d: rvalid=%b rdata=%h rresp=%b arready=%b required 1/%h/00/0", i, rvalid, rdata, rresp, arready, exp);
         end
      end
      rready = 1'b1;
      @(posedge clock); #1;
      n_checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin n_fail++; $display("FAIL bp_release: rvalid=%b arready=%b required 0/1", rvalid, arready); end
   endtask

   task automatic test_collision;
      logic [31:0] d; logic [1:0] r; int lat;
      @(negedge clock);
      araddr = 32'h30; arvalid = 1'b1;
      awaddr = 32'h34; awvalid = 1'b1; rready = 1'b1; bready = 1'b1;
      #1;
      n_checks++;
      if (arready !== 1'b1 || awready !== 1'b0) begin n_fail++; $display("FAIL coll_ready: arready=%b awready=%b required 1/0", arready, awready); end
      @(posedge clock); #1 arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < TMO) begin @(posedge clock); #1; lat++; end
      n_checks++;
      if (rdata !== model[12] || rresp !== 2'b00) begin n_fail++; $display("FAIL coll_read: rdata=%h rresp=%b required %h/00", rdata, rresp, model[12]); end
      @(posedge clock); #1;
      lat = 0;
      while (!awready && lat < TMO) begin @(posedge clock); #1; lat++; end
      @(posedge clock); #1 awvalid = 1'b0;
      wdata = 32'h5A5AC3C3; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clock); #1 wvalid = 1'b0;
      model_write(32'h34, 32'h5A5AC3C3, 4'hF);
      lat = 0;
      while (!bvalid && lat < TMO) begin @(posedge clock); #1; lat++; end
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL coll_write: bvalid=%b bresp=%b required 1/00", bvalid, bresp); end
      @(posedge clock); #1;
      do_read(32'h34, d, r, lat);
      n_checks++;
      if (d !== 32'h5A5AC3C3 || r !== 2'b00) begin n_fail++; $display("FAIL coll_readback: rdata=%h rresp=%b required 5a5ac3c3/00", d, r); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d; logic [1:0] r; int lat;
      @(negedge clock);
      awaddr = 32'h40; awvalid = 1'b1; bready = 1'b1;
      @(posedge clock); #1 awvalid = 1'b0;
      wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clock); #1 wvalid = 1'b0;
      model_write(32'h40, 32'h0BADF00D, 4'hF);
      reset = 1'b0;
      #1;
      n_checks++;
      if (bvalid !== 1'b0 || wready !== 1'b0 || arready !== 1'b1 || awready !== 1'b1 || rdata !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid: bvalid=%b wready=%b arready=%b awready=%b rdata=%h required 0/0/1/1/0",
                            bvalid, wready, arready, awready, rdata);
      end
      @(negedge clock); reset = 1'b1;
      do_read(32'h40, d, r, lat);
      n_checks++;
      if (d !== 32'h0BADF00D || r !== 2'b00) begin n_fail++; $display("FAIL rst_mid_readback: rdata=%h rresp=%b required 0badf00d/00", d, r); end
   endtask

   initial begin
      test_reset;
      test_fill;
      test_basic;
      test_strobe;
      test_oor;
      test_random;
      test_backpressure;
      test_collision;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
